// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one imem request
// in flight, and buffers returned words in a DEPTH-entry FIFO feeding IF/ID.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [31:0]            inst_out,
  output logic [31:0]            pcadd4_out,
  output logic [$clog2(DEPTH):0] count
);
  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc4_mem  [DEPTH];
  logic          issue;
  logic          push;
  logic          pop;
  logic          redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    // Issue only when a slot is guaranteed for the response, so a push never overflows.
    issue      = (state_q == S_IDLE) && (count_q < FULL) && !redirect && !rst;
    pop        = (count_q != '0) && !stall && !redirect;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d    = S_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          push    = !redirect;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The stale response must still be absorbed even if another redirect lands with it.
        if (imem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc4_mem[wr_ptr_q]  <= req_pc_q + 32'd4;
    end
  end

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign count      = count_q;
  assign inst_valid = (count_q != '0);
  assign inst_out   = inst_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign pcadd4_out = inst_valid ? pc4_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural memory with programmable latency plus a
// scoreboard of expected {instruction, PC+4} entries checked every cycle.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          stall;
  logic          inst_valid;
  logic [31:0]   inst_out;
  logic [31:0]   pcadd4_out;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .pcadd4_out (pcadd4_out),
    .count      (count)
  );

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc4;
  } redir_vec_t;

  redir_vec_t vecs [5];

  int          n_cmp = 0;
  int          n_err = 0;
  // memory model
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  int          lat = 1;
  // expected front-end state
  bit          busy = 1'b0;
  bit          dropping = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic [63:0] sb [$];
  logic [31:0] pop_log [$];
  logic [31:0] boot_addrs [$];
  bit          req_seen = 1'b0;
  logic [31:0] addr_seen = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA5A5_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit exp_req;
    bit exp_pop;
    bit ack_now;
    imem_ack   = pend && (pend_cnt == 0);
    imem_rdata = imem_ack ? word_of(pend_addr) : 32'h0;
    #1;
    ack_now   = imem_ack;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    exp_req   = !busy && (sb.size() < DEPTH) && !redirect && !rst;
    exp_pop   = (sb.size() != 0) && !stall && !redirect && !rst;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_pc);
    check("single_outstanding", 32'(imem_req && pend && !ack_now), 32'h0);
    check("count", 32'(count), 32'(sb.size()));
    check("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("inst_out", inst_out, sb[0][63:32]);
      check("pcadd4_out", pcadd4_out, sb[0][31:0]);
    end else begin
      check("inst_out_empty", inst_out, 32'h0);
      check("pcadd4_out_empty", pcadd4_out, 32'h0);
    end

    @(posedge clk);
    if (exp_pop) begin
      pop_log.push_back(sb[0][31:0]);
      $display("pop %0d: inst=%08h pc4=%08h", pop_log.size(), sb[0][63:32], sb[0][31:0]);
      void'(sb.pop_front());
    end
    if (rst) begin
      busy     = 1'b0;
      dropping = 1'b0;
    end else if (busy && ack_now) begin
      if (!dropping && !redirect) sb.push_back({imem_rdata, pend_addr + 32'd4});
      busy     = 1'b0;
      dropping = 1'b0;
    end else if (busy && redirect) begin
      dropping = 1'b1;
    end
    if (ack_now) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (rst || redirect) sb.delete();
    if (exp_req) begin
      busy   = 1'b1;
      exp_pc = exp_pc + 32'd4;
    end
    if (rst) exp_pc = RESET_PC;
    else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    if (req_seen) begin
      pend      = 1'b1;
      pend_addr = addr_seen;
      pend_cnt  = lat - 1;
    end
    #1;
  endtask

  task automatic wait_req(input string name, input bit chk_addr, input logic [31:0] exp_addr);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = req_seen;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no imem_req within 40 cycles, required addr %08h", name, exp_addr);
    end else if (chk_addr) begin
      check(name, addr_seen, exp_addr);
    end
  endtask

  task automatic wait_pop(input string name, input int base, input logic [31:0] exp_pc4);
    for (int i = 0; i < 40 && pop_log.size() <= base; i++) cycle();
    if (pop_log.size() <= base) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no pop within 40 cycles, required pc4 %08h", name, exp_pc4);
    end else begin
      check(name, pop_log[base], exp_pc4);
    end
  endtask

  initial begin
    int base;
    bit got;

    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h1234_5676, 32'h1234_5674, 32'h1234_5678};
    vecs[4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    @(posedge clk);
    #1;
    repeat (2) cycle();
    check("rst_count", 32'(count), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_pcadd4_out", pcadd4_out, 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);

    // Boot with a 1-cycle memory: requests on alternate cycles, first entry two cycles out.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (req_seen) boot_addrs.push_back(addr_seen);
      if (i < 6) check("boot_req_pattern", 32'(req_seen), 32'(i % 2 == 0));
      if (i == 0) check("boot_valid_c1", 32'(inst_valid), 32'h0);
      if (i == 1) begin
        check("boot_valid_c2", 32'(inst_valid), 32'h1);
        check("boot_first_pc4", pcadd4_out, 32'h0000_0004);
      end
    end
    check("boot_addr0", boot_addrs[0], 32'h0000_0000);
    check("boot_addr1", boot_addrs[1], 32'h0000_0004);
    check("boot_addr2", boot_addrs[2], 32'h0000_0008);
    check("boot_pop0", pop_log[0], 32'h0000_0004);
    check("boot_pop1", pop_log[1], 32'h0000_0008);
    check("boot_pop2", pop_log[2], 32'h0000_000C);

    // Redirect table: alignment of redirect_pc and the first delivered PC+4.
    foreach (vecs[k]) begin
      redirect    = 1'b1;
      redirect_pc = vecs[k].rpc;
      cycle();
      redirect = 1'b0;
      check("vec_flush_count", 32'(count), 32'h0);
      base = pop_log.size();
      wait_req("vec_addr", 1'b1, vecs[k].exp_addr);
      wait_pop("vec_pc4", base, vecs[k].exp_pc4);
    end

    // Stall fills the queue; release drains one entry per cycle while the refill is slow.
    stall = 1'b1;
    repeat (12) cycle();
    check("stall_full_count", 32'(count), 32'(DEPTH));
    check("stall_full_req", 32'(imem_req), 32'h0);
    lat   = 20;
    stall = 1'b0;
    base  = pop_log.size();
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("drain_count", 32'(count), 32'(DEPTH - 1 - i));
    end
    check("drain_pops", 32'(pop_log.size() - base), 32'(DEPTH));
    lat = 4;
    for (int i = 0; i < 30 && pend; i++) cycle();

    // Redirect while waiting on a late response.
    wait_req("late_issue", 1'b0, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    lat      = 1;
    check("late_redir_count", 32'(count), 32'h0);
    base = pop_log.size();
    wait_req("late_redir_addr", 1'b1, 32'h0000_0100);
    check("late_ack_dropped", 32'(count), 32'h0);
    wait_pop("late_redir_pc4", base, 32'h0000_0104);

    // Redirect coinciding with an ack and a would-be pop.
    stall = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = req_seen && (sb.size() >= 2);
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL coinc_setup: queue never reached 2 entries with a request in flight");
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    stall       = 1'b0;
    cycle();
    redirect = 1'b0;
    check("coinc_count", 32'(count), 32'h0);
    check("coinc_valid", 32'(inst_valid), 32'h0);
    wait_req("coinc_addr", 1'b1, 32'h0000_0200);

    // Reset while waiting; the stale ack lands the cycle after reset.
    lat = 2;
    wait_req("rst_mid_issue", 1'b0, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    lat = 1;
    check("rst_mid_count", 32'(count), 32'h0);
    wait_req("rst_mid_addr", 1'b1, RESET_PC);
    check("rst_mid_ack_ignored", 32'(count), 32'h0);

    // Fetch PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    base = pop_log.size();
    wait_req("wrap_first", 1'b1, 32'hFFFF_FFFC);
    wait_req("wrap_next", 1'b1, 32'h0000_0000);
    wait_pop("wrap_pc4", base, 32'h0000_0000);

    repeat (5) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
